// File: rtl/mini_cpu_pkg.sv
// Shared mini-cpu constants: opcodes, ALU control codes, funct fields.
package mini_cpu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

endpackage

// File: rtl/reg_file.sv
// 32 x xlen register file, two async read ports, one write port.
// x0 reads as zero and ignores writes.
module reg_file #(
  parameter int xlen = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [xlen-1:0] wdata,
  input  logic [4:0]      raddr1,
  output logic [xlen-1:0] rdata1,
  input  logic [4:0]      raddr2,
  output logic [xlen-1:0] rdata2
);

  logic [xlen-1:0] regs [1:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/alu_operand_issue.sv
// Issue stage ahead of the ALU: decode, operand read with
// write-back bypass, and a registered valid/ready output slot.
module alu_operand_issue
  import mini_cpu_pkg::*;
#(
  parameter int xlen = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [xlen-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [xlen-1:0] out_a,
  output logic [xlen-1:0] out_b,
  output logic [2:0]      out_alu_ctrl,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  logic [xlen-1:0] rf_rd1;
  logic [xlen-1:0] rf_rd2;

  reg_file #(.xlen(xlen)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .rdata1 (rf_rd1),
    .raddr2 (rs2),
    .rdata2 (rf_rd2)
  );

  logic            wb_hit;
  logic [xlen-1:0] rs1_val;
  logic [xlen-1:0] rs2_val;
  logic [xlen-1:0] imm;

  // Same-cycle write-back wins over the stored value.
  assign wb_hit  = wb_en && (wb_rd != 5'd0);
  assign rs1_val = (wb_hit && wb_rd == rs1) ? wb_data : rf_rd1;
  assign rs2_val = (wb_hit && wb_rd == rs2) ? wb_data : rf_rd2;
  assign imm     = {{(xlen-12){in_instr[31]}}, in_instr[31:20]};

  logic is_r;
  logic is_i;
  logic f7_zero;

  assign is_r    = (opcode == OPC_OP);
  assign is_i    = (opcode == OPC_OP_IMM);
  assign f7_zero = (funct7 == F7_BASE);

  logic [xlen-1:0] dec_a;
  logic [xlen-1:0] dec_b;
  logic [2:0]      dec_ctrl;
  logic [4:0]      dec_rd;
  logic            dec_ill;

  always_comb begin
    dec_a    = '0;
    dec_b    = '0;
    dec_ctrl = ALU_ADD;
    dec_rd   = '0;
    dec_ill  = 1'b0;
    unique case (1'b1)
      is_r && funct3 == F3_ADD && f7_zero: dec_ctrl = ALU_ADD;
      is_r && funct3 == F3_ADD && funct7 == F7_SUB: dec_ctrl = ALU_SUB;
      is_r && funct3 == F3_AND && f7_zero: dec_ctrl = ALU_AND;
      is_r && funct3 == F3_OR && f7_zero: dec_ctrl = ALU_OR;
      is_r && funct3 == F3_SLT && f7_zero: dec_ctrl = ALU_SLT;
      is_i && funct3 == F3_ADD: dec_ctrl = ALU_ADD;
      is_i && funct3 == F3_AND: dec_ctrl = ALU_AND;
      is_i && funct3 == F3_OR: dec_ctrl = ALU_OR;
      is_i && funct3 == F3_SLT: dec_ctrl = ALU_SLT;
      default: dec_ill = 1'b1;
    endcase
    if (!dec_ill) begin
      dec_a  = rs1_val;
      dec_b  = is_i ? imm : rs2_val;
      dec_rd = rd;
    end
  end

  logic accept;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_a        <= '0;
      out_b        <= '0;
      out_alu_ctrl <= 3'b000;
      out_rd       <= '0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_a        <= dec_a;
      out_b        <= dec_b;
      out_alu_ctrl <= dec_ctrl;
      out_rd       <= dec_rd;
      out_illegal  <= dec_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed bench for alu_operand_issue: decode, handshake,
// bypass, flush and reset scenarios with hand-computed results.
module tb_alu_operand_issue;

  localparam int xlen = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            flush;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [xlen-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [xlen-1:0] out_a;
  logic [xlen-1:0] out_b;
  logic [2:0]      out_alu_ctrl;
  logic [4:0]      out_rd;
  logic            out_illegal;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_ADDI = 32'hFFF08213;
  localparam logic [31:0] I_SUB  = 32'h402082B3;
  localparam logic [31:0] I_ADD0 = 32'h002001B3;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  always #5 clk = ~clk;

  alu_operand_issue #(.xlen(xlen)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .flush        (flush),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_a        (out_a),
    .out_b        (out_b),
    .out_alu_ctrl (out_alu_ctrl),
    .out_rd       (out_rd),
    .out_illegal  (out_illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [139:0] got;
    rst = 1'b1;
    tick();
    tick();
    got = {out_valid, out_a, out_b, out_alu_ctrl, out_rd, out_illegal};
    checks++;
    if (got !== 140'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", got);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    rst = 1'b0;
    wb_en = 1'b1;
    wb_rd = 5'd1;
    wb_data = 64'd5;
    tick();
    wb_rd = 5'd2;
    wb_data = 64'd3;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_instr = I_ADD;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_a, out_b, out_alu_ctrl, out_rd, out_illegal} !==
        {1'b1, 64'd5, 64'd3, 3'b010, 5'd3, 1'b0}) begin
      errors++;
      $display("FAIL add v=%b a=%0d b=%0d c=%b rd=%0d il=%b exp 1/5/3/010/3/0",
               out_valid, out_a, out_b, out_alu_ctrl, out_rd, out_illegal);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    in_instr = I_ADDI;
    tick();
    checks++;
    if ({out_valid, out_a, out_b, out_alu_ctrl, out_rd} !==
        {1'b1, 64'd5, {64{1'b1}}, 3'b010, 5'd4}) begin
      errors++;
      $display("FAIL addi v=%b a=%0d b=%h c=%b rd=%0d exp 1/5/ffff../010/4",
               out_valid, out_a, out_b, out_alu_ctrl, out_rd);
    end
    in_instr = I_SUB;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_a, out_b, out_alu_ctrl, out_rd} !==
        {1'b1, 64'd5, 64'd3, 3'b110, 5'd5}) begin
      errors++;
      $display("FAIL sub v=%b a=%0d b=%0d c=%b rd=%0d exp 1/5/3/110/5",
               out_valid, out_a, out_b, out_alu_ctrl, out_rd);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_decode_ops();
    logic [31:0] ins [7] = '{32'h0020F333, 32'h0020E333, 32'h0020A333,
                             32'h0070E313, 32'hFFE0A313, 32'h7FF0F313,
                             32'h4020F333};
    logic [2:0]  ctl [7] = '{3'b000, 3'b001, 3'b111, 3'b001, 3'b111,
                             3'b000, 3'b010};
    logic [63:0] bv  [7] = '{64'd3, 64'd3, 64'd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
                             64'h7FF, 64'd0};
    logic [63:0] av  [7] = '{64'd5, 64'd5, 64'd5, 64'd5, 64'd5, 64'd5, 64'd0};
    logic [4:0]  rdv [7] = '{5'd6, 5'd6, 5'd6, 5'd6, 5'd6, 5'd6, 5'd0};
    logic        ilv [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_instr = ins[i];
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_a, out_b, out_alu_ctrl, out_rd, out_illegal} !==
          {1'b1, av[i], bv[i], ctl[i], rdv[i], ilv[i]}) begin
        errors++;
        $display("FAIL decode_%0d a=%0d b=%h c=%b rd=%0d il=%b exp %0d/%h/%b/%0d/%b",
                 i, out_a, out_b, out_alu_ctrl, out_rd, out_illegal,
                 av[i], bv[i], ctl[i], rdv[i], ilv[i]);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = I_ADD;
    tick();
    in_instr = I_SUB;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({in_ready, out_valid, out_alu_ctrl, out_rd, out_a, out_b} !==
          {1'b0, 1'b1, 3'b010, 5'd3, 64'd5, 64'd3}) begin
        errors++;
        $display("FAIL stall_%0d rdy=%b v=%b c=%b rd=%0d exp 0/1/010/3",
                 i, in_ready, out_valid, out_alu_ctrl, out_rd);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready got=%b exp=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_alu_ctrl, out_rd} !== {1'b1, 3'b110, 5'd5}) begin
      errors++;
      $display("FAIL stall_next v=%b c=%b rd=%0d exp 1/110/5",
               out_valid, out_alu_ctrl, out_rd);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_no_dup got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_bypass();
    wb_en = 1'b1;
    wb_rd = 5'd1;
    wb_data = 64'd42;
    in_valid = 1'b1;
    in_instr = I_ADD;
    tick();
    in_valid = 1'b0;
    wb_en = 1'b0;
    checks++;
    if ({out_a, out_b} !== {64'd42, 64'd3}) begin
      errors++;
      $display("FAIL bypass_rs1 a=%0d b=%0d exp 42/3", out_a, out_b);
    end
    tick();
    wb_en = 1'b1;
    wb_rd = 5'd0;
    wb_data = 64'd99;
    in_valid = 1'b1;
    in_instr = I_ADD0;
    tick();
    wb_en = 1'b0;
    checks++;
    if ({out_a, out_b} !== {64'd0, 64'd3}) begin
      errors++;
      $display("FAIL bypass_x0 a=%0d b=%0d exp 0/3", out_a, out_b);
    end
    in_instr = I_ADD;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_a !== 64'd42) begin
      errors++;
      $display("FAIL bypass_stored a=%0d exp 42", out_a);
    end
    tick();
  endtask

  task automatic test_illegal_flush();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = I_BAD;
    tick();
    checks++;
    if ({out_valid, out_illegal, out_rd, out_alu_ctrl, out_a, out_b} !==
        {1'b1, 1'b1, 5'd0, 3'b010, 64'd0, 64'd0}) begin
      errors++;
      $display("FAIL illegal v=%b il=%b rd=%0d c=%b exp 1/1/0/010",
               out_valid, out_illegal, out_rd, out_alu_ctrl);
    end
    out_ready = 1'b1;
    flush = 1'b1;
    in_instr = I_ADD;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready got=%b exp=0", in_ready);
    end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [139:0] got;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = I_ADD;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got = {out_valid, out_a, out_b, out_alu_ctrl, out_rd, out_illegal};
    checks++;
    if (got !== 140'd0) begin
      errors++;
      $display("FAIL rst_stall got=%h exp=0", got);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_a, out_b} !== {1'b1, 64'd0, 64'd0}) begin
      errors++;
      $display("FAIL rst_regs v=%b a=%0d b=%0d exp 1/0/0",
               out_valid, out_a, out_b);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    flush = 1'b0;
    wb_en = 1'b0;
    wb_rd = '0;
    wb_data = '0;
    out_ready = 1'b1;
    test_reset();
    test_add();
    test_back_to_back();
    test_decode_ops();
    test_stall();
    test_bypass();
    test_illegal_flush();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
